// File: rtl/config_frame_writer_pkg.sv
// Shared types and constants for the configuration frame writer.
package config_frame_writer_pkg;

   // Session parser states; SETUP/PULSE/HOLD frame the strobe around stable data
   typedef enum logic [2:0] {
      HUNT,
      ADDR,
      DATA,
      SETUP,
      PULSE,
      HOLD
   } cfwState_e;

   localparam logic [31:0] DefaultSyncWord = 32'hFAB0_FAB1;
   localparam int unsigned EndMarkerBit    = 31;
   localparam int unsigned FramesWrittenW  = 16;

endpackage

// File: rtl/config_frame_writer.sv
// Configuration frame writer: parses a sync-framed bitstream of
// (address, data) word pairs and writes each frame with a one-hot strobe.
module config_frame_writer
   import config_frame_writer_pkg::*;
#(
   parameter int unsigned MaxFramesPerCol = 20,
   parameter int unsigned FrameBitsPerRow = 32,
   parameter logic [31:0] SyncWord        = DefaultSyncWord
) (
   input  logic                       CLK,
   input  logic                       reset,
   input  logic [FrameBitsPerRow-1:0] s_data,
   input  logic                       s_valid,
   output logic                       s_ready,
   output logic [FrameBitsPerRow-1:0] FrameData,
   output logic [MaxFramesPerCol-1:0] FrameStrobe,
   output logic                       busy,
   output logic                       err,
   output logic [FramesWrittenW-1:0]  frames_written
);

   localparam int unsigned IdxW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
   localparam logic [FrameBitsPerRow-1:0] SyncFull = FrameBitsPerRow'(SyncWord);

   cfwState_e       state;
   cfwState_e       stateNext;
   logic [IdxW-1:0] frameIdx;
   logic            dropped;
   logic            accept;
   logic            isSync;
   logic            isEnd;
   logic [IdxW-1:0] addrIdx;
   logic            idxOutOfRange;

   // State register
   always_ff @(posedge CLK) begin
      if (reset) begin
         state <= HUNT;
      end else begin
         state <= stateNext;
      end
   end

   // Word decode and next-state selection; only handshaked words move the parser
   always_comb begin
      accept        = s_valid & s_ready;
      isSync        = (s_data == SyncFull);
      isEnd         = s_data[EndMarkerBit];
      addrIdx       = s_data[IdxW-1:0];
      idxOutOfRange = (32'(addrIdx) >= MaxFramesPerCol);
      stateNext     = state;
      case (state)
         HUNT: begin
            if (accept && isSync) stateNext = ADDR;
         end
         ADDR: begin
            if (accept) stateNext = isEnd ? HUNT : DATA;
         end
         DATA: begin
            if (accept) stateNext = dropped ? ADDR : SETUP;
         end
         SETUP:   stateNext = PULSE;
         PULSE:   stateNext = HOLD;
         HOLD:    stateNext = ADDR;
         default: stateNext = HUNT;
      endcase
   end

   // Registered outputs derived from the upcoming state, plus index/data capture
   always_ff @(posedge CLK) begin
      if (reset) begin
         s_ready        <= 1'b1;
         busy           <= 1'b0;
         err            <= 1'b0;
         FrameStrobe    <= '0;
         FrameData      <= '0;
         frames_written <= '0;
         frameIdx       <= '0;
         dropped        <= 1'b0;
      end else begin
         s_ready     <= (stateNext == HUNT) || (stateNext == ADDR) || (stateNext == DATA);
         busy        <= (stateNext != HUNT);
         FrameStrobe <= '0;
         if (stateNext == PULSE) begin
            FrameStrobe    <= MaxFramesPerCol'(1) << frameIdx;
            frames_written <= frames_written + FramesWrittenW'(1);
         end
         if ((state == ADDR) && accept && !isEnd) begin
            frameIdx <= addrIdx;
            dropped  <= idxOutOfRange;
            if (idxOutOfRange) err <= 1'b1;
         end
         if ((state == DATA) && accept) begin
            FrameData <= s_data;
         end
      end
   end

endmodule

// File: tb/tb_config_frame_writer.sv
// Self-checking bench for config_frame_writer: directed scenarios plus a
// randomized session checked against a stream-parsing reference model.
module tb_config_frame_writer;

   localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
   localparam int          MAXF = 20;

   logic        CLK = 1'b0;
   logic        reset;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic [31:0] FrameData;
   logic [19:0] FrameStrobe;
   logic        busy;
   logic        err;
   logic [15:0] frames_written;

   int tests = 0;
   int fails = 0;

   int          obsIdx[$];
   logic [31:0] obsData[$];
   int          expIdx[$];
   logic [31:0] expData[$];
   logic        expErr;
   logic [31:0] stream[$];

   logic [19:0] prevStrobe   = '0;
   logic        prevReady    = 1'b1;
   logic [31:0] prevData     = '0;
   logic        pendingAfter = 1'b0;
   logic [31:0] strobeData   = '0;

   config_frame_writer #(
      .MaxFramesPerCol(20),
      .FrameBitsPerRow(32),
      .SyncWord(32'hFAB0_FAB1)
   ) dut (
      .CLK(CLK),
      .reset(reset),
      .s_data(s_data),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .FrameData(FrameData),
      .FrameStrobe(FrameStrobe),
      .busy(busy),
      .err(err),
      .frames_written(frames_written)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Strobe monitor: one-hot, single cycle, data stable around it, no ready
   initial begin
      int k;
      forever begin
         @(negedge CLK);
         if (reset) begin
            pendingAfter = 1'b0;
         end else begin
            if (pendingAfter) begin
               chk("data_after_strobe", FrameData, strobeData);
               chk("ready_after_strobe", 32'(s_ready), 0);
               pendingAfter = 1'b0;
            end
            if (FrameStrobe != 0) begin
               chk("onehot", 32'($onehot(FrameStrobe)), 1);
               chk("single_cycle", 32'(prevStrobe), 0);
               chk("data_before_strobe", FrameData, prevData);
               chk("ready_before_strobe", 32'(prevReady), 0);
               chk("ready_in_strobe", 32'(s_ready), 0);
               k = -1;
               for (int i = 0; i < MAXF; i++) if (FrameStrobe[i]) k = i;
               obsIdx.push_back(k);
               obsData.push_back(FrameData);
               pendingAfter = 1'b1;
               strobeData   = FrameData;
            end
         end
         prevStrobe = FrameStrobe;
         prevReady  = s_ready;
         prevData   = FrameData;
      end
   end

   // Present one word with optional random idle gap; returns at the negedge after acceptance
   task automatic sendWord(input logic [31:0] w, input int gapPct);
      int waitN = 0;
      while (int'($urandom_range(99)) < gapPct) begin
         s_valid = 1'b0;
         s_data  = $urandom;
         @(negedge CLK);
      end
      s_valid = 1'b1;
      s_data  = w;
      while (!s_ready && waitN < 50) begin
         @(negedge CLK);
         waitN++;
      end
      chk("handshake", 32'(s_ready), 1);
      @(negedge CLK);
      s_valid = 1'b0;
      s_data  = $urandom;
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      repeat (n) @(negedge CLK);
   endtask

   task automatic sendStream(input int gapPct);
      foreach (stream[i]) sendWord(stream[i], gapPct);
      idle(8);
   endtask

   // Reference: scan the word stream for sessions and list the frames they write
   task automatic modelStream();
      int          p = 0;
      int          idx;
      logic [31:0] d;
      logic [31:0] w;
      while (p < stream.size()) begin
         while (p < stream.size() && stream[p] !== SYNC) p++;
         if (p >= stream.size()) break;
         p++;
         while (p < stream.size()) begin
            w = stream[p];
            p++;
            if (w[31]) break;
            idx = int'(w[4:0]);
            if (p >= stream.size()) break;
            d = stream[p];
            p++;
            if (idx >= MAXF) begin
               expErr = 1'b1;
            end else begin
               expIdx.push_back(idx);
               expData.push_back(d);
            end
         end
      end
   endtask

   task automatic compareFrames(input string tag);
      chk({tag, "_count"}, 32'(obsIdx.size()), 32'(expIdx.size()));
      for (int i = 0; i < obsIdx.size() && i < expIdx.size(); i++) begin
         chk({tag, "_idx"}, 32'(obsIdx[i]), 32'(expIdx[i]));
         chk({tag, "_data"}, obsData[i], expData[i]);
      end
   endtask

   task automatic clearScoreboard();
      obsIdx.delete();
      obsData.delete();
      expIdx.delete();
      expData.delete();
      stream.delete();
      expErr = 1'b0;
   endtask

   task automatic doReset();
      s_valid = 1'b0;
      reset   = 1'b1;
      repeat (2) @(negedge CLK);
      reset = 1'b0;
      clearScoreboard();
   endtask

   initial begin
      int          n;
      int          idx;
      int          r;
      logic [31:0] g;

      reset   = 1'b1;
      s_valid = 1'b0;
      s_data  = '0;
      repeat (3) @(negedge CLK);
      chk("rst_ready", 32'(s_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_strobe", 32'(FrameStrobe), 0);
      chk("rst_data", FrameData, 0);
      chk("rst_count", 32'(frames_written), 0);
      reset = 1'b0;
      clearScoreboard();

      // Basic frame and latency: addr 3, DEADBEEF
      sendWord(SYNC, 0);
      sendWord(32'd3, 0);
      sendWord(32'hDEADBEEF, 0);
      chk("lat_data_n1", FrameData, 32'hDEADBEEF);
      chk("lat_strobe_n1", 32'(FrameStrobe), 0);
      chk("lat_ready_n1", 32'(s_ready), 0);
      chk("lat_busy_n1", 32'(busy), 1);
      @(negedge CLK);
      chk("lat_strobe_n2", 32'(FrameStrobe), 32'h0000_0008);
      chk("lat_count_n2", 32'(frames_written), 1);
      @(negedge CLK);
      chk("lat_strobe_n3", 32'(FrameStrobe), 0);
      chk("lat_ready_n3", 32'(s_ready), 0);
      @(negedge CLK);
      chk("lat_ready_n4", 32'(s_ready), 1);
      chk("lat_busy_n4", 32'(busy), 1);
      stream = {SYNC, 32'd3, 32'hDEADBEEF};
      modelStream();
      compareFrames("basic");
      sendWord(32'h8000_0000, 0);
      chk("basic_end_busy", 32'(busy), 0);

      // Garbage before sync is discarded
      doReset();
      stream = {32'h1234_5678, SYNC, 32'd0, 32'd1, 32'h8000_0000};
      sendStream(0);
      modelStream();
      compareFrames("garbage");
      chk("garbage_count", 32'(frames_written), 1);

      // Out-of-range index sets err and drops only that frame
      doReset();
      stream = {SYNC, 32'd25, 32'd5, 32'd19, 32'd7};
      sendStream(30);
      modelStream();
      compareFrames("range");
      chk("range_err", 32'(err), 32'(expErr));
      chk("range_err_set", 32'(err), 1);
      chk("range_count", 32'(frames_written), 1);

      // Randomized sessions with stalls, sync-as-data and bad indices
      for (int rep = 0; rep < 3; rep++) begin
         doReset();
         for (int j = 0; j < 2; j++) begin
            g = $urandom;
            if (g == SYNC) g = g ^ 32'd1;
            stream.push_back(g);
         end
         stream.push_back(SYNC);
         for (int f = 0; f < 20; f++) begin
            r   = int'($urandom_range(9));
            idx = (r == 0) ? int'($urandom_range(31, 20)) : int'($urandom_range(19, 0));
            stream.push_back({1'b0, 26'($urandom), 5'(idx)});
            stream.push_back((r == 1) ? SYNC : 32'($urandom));
         end
         stream.push_back(32'h8000_0000);
         for (int j = 0; j < 2; j++) begin
            g = {1'b0, 31'($urandom)};
            stream.push_back(g);
         end
         sendStream(40);
         modelStream();
         compareFrames("random");
         chk("random_err", 32'(err), 32'(expErr));
         chk("random_count", 32'(frames_written), 32'(expIdx.size()));
         chk("random_busy", 32'(busy), 0);
      end

      // End marker returns to HUNT; following non-sync words are ignored
      doReset();
      stream = {SYNC, 32'd0, 32'hAAAA_0000, 32'd5, 32'hBBBB_0000, 32'h8000_0000, 32'd2, 32'd9};
      sendStream(0);
      modelStream();
      compareFrames("endses");
      chk("endses_busy", 32'(busy), 0);
      chk("endses_count", 32'(frames_written), 2);

      // Reset landing in the strobe cycle
      doReset();
      sendWord(SYNC, 0);
      sendWord(32'd4, 0);
      sendWord(32'hCAFE_F00D, 0);
      n = 0;
      while (FrameStrobe == 0 && n < 10) begin
         @(negedge CLK);
         n++;
      end
      chk("pulse_seen", 32'(FrameStrobe), 32'h0000_0010);
      reset = 1'b1;
      @(negedge CLK);
      chk("pulse_rst_strobe", 32'(FrameStrobe), 0);
      chk("pulse_rst_ready", 32'(s_ready), 1);
      chk("pulse_rst_busy", 32'(busy), 0);
      chk("pulse_rst_err", 32'(err), 0);
      chk("pulse_rst_count", 32'(frames_written), 0);
      chk("pulse_rst_data", FrameData, 0);
      reset = 1'b0;
      clearScoreboard();
      sendWord(32'd3, 0);
      sendWord(32'd5, 0);
      idle(6);
      chk("pulse_hunt_nostrobe", 32'(obsIdx.size()), 0);
      chk("pulse_hunt_busy", 32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/config_frame_writer.md
CONFIG_FRAME_WRITER -- requirements
Module: config_frame_writer

Interface
REQ-001 SHALL have parameter MaxFramesPerCol, default 20, number of frame strobes per column.
REQ-002 SHALL have parameter FrameBitsPerRow, default 32, width of frame data and of every input word (min 32).
REQ-003 SHALL have parameter SyncWord, default 32'hFAB0_FAB1, word that opens a configuration session.
REQ-004 SHALL have one clock and a synchronous, active-high reset: CLK  input  1  clock, all logic on rising edge.
REQ-005 SHALL have reset  input  1  synchronous active-high reset.
REQ-006 SHALL have s_data  input  FrameBitsPerRow  bitstream word.
REQ-007 SHALL have s_valid  input  1  s_data valid.
REQ-008 SHALL have s_ready  output  1  word accepted when s_valid and s_ready are both high on a CLK edge.
REQ-009 SHALL have FrameData  output  FrameBitsPerRow  frame data to config memories.
REQ-010 SHALL have FrameStrobe  output  MaxFramesPerCol  one-hot frame write strobe.
REQ-011 SHALL have busy  output  1  high in every state except HUNT.
REQ-012 SHALL have err  output  1  sticky error flag.
REQ-013 SHALL have frames_written  output  16  count of strobes issued since reset.

Function
REQ-014 SHALL implement states HUNT, ADDR, DATA, SETUP, PULSE, HOLD.
REQ-015 HUNT: s_ready=1; accepted word equal to SyncWord -> ADDR; any other word discarded, stay HUNT.
REQ-016 ADDR: s_ready=1; accepted word bit[31]=1 -> HUNT (end of session); else bits[IW-1:0], IW=clog2(MaxFramesPerCol), latched as frame index -> DATA.
REQ-017 ADDR: index >= MaxFramesPerCol SHALL set err and mark frame dropped; DATA word still consumed.
REQ-018 DATA: s_ready=1; accepted word latched into FrameData register -> SETUP, or -> ADDR if frame dropped.
REQ-019 SETUP, PULSE, HOLD: s_ready=0, one cycle each; FrameData held constant.
REQ-020 PULSE: FrameStrobe = one-hot bit[index]; all other cycles FrameStrobe = 0.
REQ-021 HOLD -> ADDR; frames_written increments by 1 on the PULSE cycle, wraps 16'hFFFF -> 0.
REQ-022 Latency: data word accepted at edge N -> FrameData valid after N, strobe high in cycle N+2, ready again in cycle N+4.
REQ-023 FrameData SHALL change only on DATA acceptance or reset; stable ≥1 cycle before and after every strobe.
REQ-024 s_valid low in any state SHALL stall without state change; s_data ignored when not accepted.
REQ-025 SyncWord arriving in ADDR or DATA SHALL be treated as ordinary data (no resync).
REQ-026 FrameStrobe SHALL never have more than one bit set.

Reset
REQ-027 reset SHALL force HUNT, FrameData=0, FrameStrobe=0, s_ready=1 in following cycle, busy=0, err=0, frames_written=0, index=0.
REQ-028 reset asserted during PULSE SHALL drop FrameStrobe to 0 at the next edge; interrupted frame not counted beyond the PULSE already taken.
REQ-029 err SHALL clear only by reset.

Structure
REQ-030 Shared package SHALL hold state enum, default SyncWord, end-marker bit position.
REQ-031 Single module, no sub-modules; index-to-one-hot decode inline.
REQ-032 All outputs registered; no combinational path s_valid -> s_ready.

Verification
REQ-033 Reset, then SyncWord, addr 3, data 32'hDEADBEEF -> FrameData=DEADBEEF, FrameStrobe=20'h00008 for exactly one cycle, frames_written=1.
REQ-034 Garbage 32'h12345678 in HUNT, then SyncWord, addr 0, data 1 -> garbage ignored, strobe bit0 only.
REQ-035 SyncWord, addr 25, data 5, addr 19, data 7 -> err=1, no strobe for 25, strobe bit19 with FrameData=7, frames_written=1.
REQ-036 s_valid toggling randomly over 20 frames -> every strobe one-hot, FrameData stable SETUP..HOLD, s_ready=0 during SETUP/PULSE/HOLD.
REQ-037 reset asserted in PULSE -> FrameStrobe=0 next cycle, state HUNT, err=0, frames_written=0.
REQ-038 SyncWord, 2 frames, end word 32'h80000000 -> busy=0, back in HUNT, next non-sync word ignored.
